// File: rtl/scr1_tapc_sync_mc.sv
// TAP-to-core synchroniser: samples TCK and TAP channel signals in the clk domain,
// filters TCK, and turns its edges into one-cycle strobes for the DMI/SCU channels.
module scr1_tapc_sync_mc #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2,
  parameter int MIN_HALF    = 4,
  parameter int NUM_CH      = 2,
  parameter int CH_ID_W     = 2
) (
  input  logic               clk,
  input  logic               pwrup_rst_n,
  input  logic               tapc_tck,
  input  logic               tapc_trst_n,
  input  logic [NUM_CH-1:0]  tapc2tapcsync_ch_sel_i,
  input  logic [CH_ID_W-1:0] tapc2tapcsync_ch_id_i,
  input  logic               tapc2tapcsync_ch_capture_i,
  input  logic               tapc2tapcsync_ch_shift_i,
  input  logic               tapc2tapcsync_ch_update_i,
  input  logic               tapc2tapcsync_ch_tdi_i,
  output logic               tapcsync2tapc_ch_tdo_o,
  output logic [NUM_CH-1:0]  tapcsync2core_ch_sel_o,
  output logic [CH_ID_W-1:0] tapcsync2core_ch_id_o,
  output logic               tapcsync2core_ch_capture_o,
  output logic               tapcsync2core_ch_shift_o,
  output logic               tapcsync2core_ch_tdi_o,
  output logic               tapcsync2core_ch_update_o,
  input  logic               core2tapcsync_ch_tdo_i,
  output logic               tapcsync2core_tck_rise_o,
  output logic               tapcsync2core_tck_fall_o,
  output logic [1:0]         tapcsync_err_o
);

  localparam int DW     = NUM_CH + CH_ID_W + 6;
  localparam int FCNT_W = $clog2(FILT_LEN + 1);
  localparam int HCNT_W = $clog2(MIN_HALF + 1);
  localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_LEN - 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(MIN_HALF);
  localparam logic [HCNT_W-1:0] HCNT_LIM  = HCNT_W'(MIN_HALF - 1);

  function automatic logic onehot0(input logic [NUM_CH-1:0] v);
    return (v & (v - NUM_CH'(1))) == '0;
  endfunction

  logic [DW-1:0]                  sync_in;
  logic [SYNC_STAGES-1:0][DW-1:0] sync_d, sync_q;
  logic [DW-1:0]                  sync_out;
  logic                           tck_s, trst_n_s, cap_s, shift_s, upd_s, tdi_s;
  logic [NUM_CH-1:0]              sel_s;
  logic [CH_ID_W-1:0]             id_s;

  logic               tck_f_d, tck_f_q, tck_fd_d, tck_fd_q;
  logic [FCNT_W-1:0]  fcnt_d, fcnt_q;
  logic [HCNT_W-1:0]  hcnt_d, hcnt_q;
  logic               flip;
  logic               rise_d, rise_q, fall_d, fall_q;
  logic               cap_d, cap_q, shift_d, shift_q, tdi_d, tdi_q, upd_d, upd_q, tdo_d, tdo_q;
  logic [NUM_CH-1:0]  sel_d, sel_q;
  logic [CH_ID_W-1:0] id_d, id_q;
  logic [1:0]         err_d, err_q;

  assign sync_in  = {tapc_tck, tapc_trst_n, tapc2tapcsync_ch_sel_i, tapc2tapcsync_ch_id_i,
                     tapc2tapcsync_ch_capture_i, tapc2tapcsync_ch_shift_i,
                     tapc2tapcsync_ch_update_i, tapc2tapcsync_ch_tdi_i};
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign tck_s    = sync_out[DW-1];
  assign trst_n_s = sync_out[DW-2];
  assign sel_s    = sync_out[4+CH_ID_W +: NUM_CH];
  assign id_s     = sync_out[4 +: CH_ID_W];
  assign cap_s    = sync_out[3];
  assign shift_s  = sync_out[2];
  assign upd_s    = sync_out[1];
  assign tdi_s    = sync_out[0];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sync_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    tck_f_d  = tck_f_q;
    tck_fd_d = tck_f_q;
    fcnt_d   = fcnt_q;
    hcnt_d   = hcnt_q;
    flip     = 1'b0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    cap_d    = 1'b0;
    shift_d  = 1'b0;
    tdi_d    = 1'b0;
    upd_d    = 1'b0;
    tdo_d    = tdo_q;
    sel_d    = sel_q;
    id_d     = id_q;
    err_d    = err_q;
    if (!trst_n_s) begin
      tck_f_d  = 1'b0;
      tck_fd_d = 1'b0;
      fcnt_d   = '0;
      hcnt_d   = HCNT_MAX;
      tdo_d    = 1'b0;
      sel_d    = '0;
      id_d     = '0;
      err_d    = 2'b00;
    end else begin
      // A level change is accepted only after FILT_LEN consecutive differing samples.
      if (tck_s != tck_f_q) begin
        if (fcnt_q == FILT_LAST) begin
          flip    = 1'b1;
          tck_f_d = tck_s;
          fcnt_d  = '0;
        end else begin
          fcnt_d  = fcnt_q + FCNT_W'(1);
        end
      end else begin
        fcnt_d = '0;
      end
      if (flip) begin
        hcnt_d = '0;
        if (hcnt_q < HCNT_LIM) begin
          err_d[0] = 1'b1;
        end else begin
          err_d[0] = err_q[0];
        end
      end else if (hcnt_q != HCNT_MAX) begin
        hcnt_d = hcnt_q + HCNT_W'(1);
      end else begin
        hcnt_d = hcnt_q;
      end
      rise_d = tck_f_q & ~tck_fd_q;
      fall_d = ~tck_f_q & tck_fd_q;
      if (rise_d) begin
        cap_d   = cap_s;
        shift_d = shift_s;
        tdi_d   = tdi_s;
        id_d    = id_s;
        if (onehot0(sel_s)) begin
          sel_d = sel_s;
        end else begin
          sel_d    = '0;
          err_d[1] = 1'b1;
        end
      end else begin
        sel_d = sel_q;
      end
      if (fall_d) begin
        upd_d = upd_s;
        tdo_d = core2tapcsync_ch_tdo_i;
      end else begin
        tdo_d = tdo_q;
      end
    end
  end

  // hcnt starts saturated so the first TCK edge after reset is never flagged as overrun.
  always_ff @(posedge clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) begin
      sync_q   <= '0;
      tck_f_q  <= 1'b0;
      tck_fd_q <= 1'b0;
      fcnt_q   <= '0;
      hcnt_q   <= HCNT_MAX;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cap_q    <= 1'b0;
      shift_q  <= 1'b0;
      tdi_q    <= 1'b0;
      upd_q    <= 1'b0;
      tdo_q    <= 1'b0;
      sel_q    <= '0;
      id_q     <= '0;
      err_q    <= 2'b00;
    end else begin
      sync_q   <= sync_d;
      tck_f_q  <= tck_f_d;
      tck_fd_q <= tck_fd_d;
      fcnt_q   <= fcnt_d;
      hcnt_q   <= hcnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cap_q    <= cap_d;
      shift_q  <= shift_d;
      tdi_q    <= tdi_d;
      upd_q    <= upd_d;
      tdo_q    <= tdo_d;
      sel_q    <= sel_d;
      id_q     <= id_d;
      err_q    <= err_d;
    end
  end

  assign tapcsync2tapc_ch_tdo_o     = tdo_q;
  assign tapcsync2core_ch_sel_o     = sel_q;
  assign tapcsync2core_ch_id_o      = id_q;
  assign tapcsync2core_ch_capture_o = cap_q;
  assign tapcsync2core_ch_shift_o   = shift_q;
  assign tapcsync2core_ch_tdi_o     = tdi_q;
  assign tapcsync2core_ch_update_o  = upd_q;
  assign tapcsync2core_tck_rise_o   = rise_q;
  assign tapcsync2core_tck_fall_o   = fall_q;
  assign tapcsync_err_o             = err_q;

endmodule

// File: tb/tb_scr1_tapc_sync_mc.sv
// Directed bench for scr1_tapc_sync_mc: default instance plus a FILT_LEN=3 instance for glitch tests.
module tb_scr1_tapc_sync_mc;

  logic       clk = 1'b0;
  logic       pwrup_rst_n = 1'b0;
  logic       tapc_tck = 1'b0;
  logic       tck3 = 1'b0;
  logic       tapc_trst_n = 1'b1;
  logic [1:0] sel_i = 2'b00;
  logic [1:0] id_i = 2'b00;
  logic       cap_i = 1'b0, shift_i = 1'b0, upd_i = 1'b0, tdi_i = 1'b0, core_tdo = 1'b0;

  logic       tdo_o, cap_o, sh_o, tdi_o, upd_o, rise_o, fall_o;
  logic [1:0] sel_o, id_o, err_o;
  logic       f3_tdo, f3_cap, f3_sh, f3_tdi, f3_upd, f3_rise, f3_fall;
  logic [1:0] f3_sel, f3_id, f3_err;

  int total = 0;
  int bad = 0;
  logic [1:0] exp_sel = 2'b00, exp_id = 2'b00, exp_err = 2'b00;
  logic       exp_tdo = 1'b0;
  int nr, nf;

  always #5 clk = ~clk;

  scr1_tapc_sync_mc u_dut (
    .clk(clk), .pwrup_rst_n(pwrup_rst_n), .tapc_tck(tapc_tck), .tapc_trst_n(tapc_trst_n),
    .tapc2tapcsync_ch_sel_i(sel_i), .tapc2tapcsync_ch_id_i(id_i),
    .tapc2tapcsync_ch_capture_i(cap_i), .tapc2tapcsync_ch_shift_i(shift_i),
    .tapc2tapcsync_ch_update_i(upd_i), .tapc2tapcsync_ch_tdi_i(tdi_i),
    .tapcsync2tapc_ch_tdo_o(tdo_o), .tapcsync2core_ch_sel_o(sel_o), .tapcsync2core_ch_id_o(id_o),
    .tapcsync2core_ch_capture_o(cap_o), .tapcsync2core_ch_shift_o(sh_o),
    .tapcsync2core_ch_tdi_o(tdi_o), .tapcsync2core_ch_update_o(upd_o),
    .core2tapcsync_ch_tdo_i(core_tdo), .tapcsync2core_tck_rise_o(rise_o),
    .tapcsync2core_tck_fall_o(fall_o), .tapcsync_err_o(err_o)
  );

  scr1_tapc_sync_mc #(.FILT_LEN(3)) u_f3 (
    .clk(clk), .pwrup_rst_n(pwrup_rst_n), .tapc_tck(tck3), .tapc_trst_n(tapc_trst_n),
    .tapc2tapcsync_ch_sel_i(sel_i), .tapc2tapcsync_ch_id_i(id_i),
    .tapc2tapcsync_ch_capture_i(cap_i), .tapc2tapcsync_ch_shift_i(shift_i),
    .tapc2tapcsync_ch_update_i(upd_i), .tapc2tapcsync_ch_tdi_i(tdi_i),
    .tapcsync2tapc_ch_tdo_o(f3_tdo), .tapcsync2core_ch_sel_o(f3_sel), .tapcsync2core_ch_id_o(f3_id),
    .tapcsync2core_ch_capture_o(f3_cap), .tapcsync2core_ch_shift_o(f3_sh),
    .tapcsync2core_ch_tdi_o(f3_tdi), .tapcsync2core_ch_update_o(f3_upd),
    .core2tapcsync_ch_tdo_i(core_tdo), .tapcsync2core_tck_rise_o(f3_rise),
    .tapcsync2core_tck_fall_o(f3_fall), .tapcsync_err_o(f3_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tdo"}, {7'd0, tdo_o}, 8'd0);
    chk({tag, "_sel"}, {6'd0, sel_o}, 8'd0);
    chk({tag, "_id"}, {6'd0, id_o}, 8'd0);
    chk({tag, "_strb"}, {3'd0, cap_o, sh_o, tdi_o, upd_o, 1'b0}, 8'd0);
    chk({tag, "_edge"}, {6'd0, rise_o, fall_o}, 8'd0);
    chk({tag, "_err"}, {6'd0, err_o}, 8'd0);
  endtask

  // Raise TCK at a negedge and check the 4-cycle strobe latency and 1-cycle width.
  task automatic do_rise(input logic tdi_v, input logic cap_v);
    cap_i = cap_v; shift_i = 1'b1; tdi_i = tdi_v; tapc_tck = 1'b1;
    repeat (4) @(negedge clk);
    chk("rise_early", {7'd0, rise_o}, 8'd0);
    @(negedge clk);
    chk("rise", {7'd0, rise_o}, 8'd1);
    chk("shift", {7'd0, sh_o}, 8'd1);
    chk("tdi", {7'd0, tdi_o}, {7'd0, tdi_v});
    chk("capture", {7'd0, cap_o}, {7'd0, cap_v});
    chk("sel", {6'd0, sel_o}, {6'd0, exp_sel});
    chk("id", {6'd0, id_o}, {6'd0, exp_id});
    chk("err_r", {6'd0, err_o}, {6'd0, exp_err});
    chk("tdo_hold", {7'd0, tdo_o}, {7'd0, exp_tdo});
    @(negedge clk);
    chk("rise_1cyc", {7'd0, rise_o}, 8'd0);
    chk("strb_1cyc", {5'd0, cap_o, sh_o, tdi_o}, 8'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_fall(input logic upd_v, input logic tdo_v);
    upd_i = upd_v; core_tdo = tdo_v; tapc_tck = 1'b0;
    repeat (4) @(negedge clk);
    chk("fall_early", {7'd0, fall_o}, 8'd0);
    chk("tdo_old", {7'd0, tdo_o}, {7'd0, exp_tdo});
    @(negedge clk);
    exp_tdo = tdo_v;
    chk("fall", {7'd0, fall_o}, 8'd1);
    chk("update", {7'd0, upd_o}, {7'd0, upd_v});
    chk("tdo_new", {7'd0, tdo_o}, {7'd0, exp_tdo});
    chk("sel_held", {6'd0, sel_o}, {6'd0, exp_sel});
    chk("id_held", {6'd0, id_o}, {6'd0, exp_id});
    chk("err_f", {6'd0, err_o}, {6'd0, exp_err});
    @(negedge clk);
    chk("fall_1cyc", {6'd0, fall_o, upd_o}, 8'd0);
    chk("tdo_keep", {7'd0, tdo_o}, {7'd0, exp_tdo});
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("in_reset");
    pwrup_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_all_zero("post_reset");
    chk("f3_reset", {f3_rise, f3_fall, f3_sh, f3_tdi, f3_err, f3_sel}, 8'd0);

    // Clean TCK, alternating TDI, update/TDO handling.
    sel_i = 2'b01; id_i = 2'd2; exp_sel = 2'b01; exp_id = 2'd2;
    do_rise(1'b1, 1'b0);
    do_fall(1'b0, 1'b0);
    do_rise(1'b0, 1'b1);
    do_fall(1'b1, 1'b1);
    do_rise(1'b1, 1'b0);
    do_fall(1'b1, 1'b0);

    // Legal select, then illegal multi-select.
    sel_i = 2'b10; id_i = 2'd1; exp_sel = 2'b10; exp_id = 2'd1;
    do_rise(1'b0, 1'b0);
    do_fall(1'b0, 1'b0);
    sel_i = 2'b11; exp_sel = 2'b00; exp_err = 2'b10;
    do_rise(1'b1, 1'b0);
    do_fall(1'b0, 1'b0);
    sel_i = 2'b01;

    // Overrun: TCK toggles every 2 clk.
    nr = 0; nf = 0;
    for (int i = 0; i < 16; i++) begin
      if ((i % 2 == 0) && (i < 8)) tapc_tck = ~tapc_tck;
      @(negedge clk);
      nr += int'(rise_o);
      nf += int'(fall_o);
    end
    chk("ovr_rises", nr[7:0], 8'd2);
    chk("ovr_falls", nf[7:0], 8'd2);
    chk("ovr_err", {6'd0, err_o}, 8'd3);

    // TAP reset clears everything within SYNC_STAGES+1 cycles.
    tapc_trst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("trst");
    tapc_trst_n = 1'b1;
    nr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nr += int'(rise_o) + int'(fall_o);
    end
    chk("trst_rel_edges", nr[7:0], 8'd0);
    exp_sel = 2'b00; exp_id = 2'd0; exp_err = 2'b00; exp_tdo = 1'b0;

    // Glitch rejection with FILT_LEN=3: 2-cycle pulse ignored, 3-cycle pulse accepted.
    nr = 0; nf = 0;
    tck3 = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 1) tck3 = 1'b0;
      nr += int'(f3_rise);
      nf += int'(f3_fall);
    end
    chk("glitch2_rises", nr[7:0], 8'd0);
    chk("glitch2_falls", nf[7:0], 8'd0);
    nr = 0; nf = 0;
    tck3 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 2) tck3 = 1'b0;
      nr += int'(f3_rise);
      nf += int'(f3_fall);
    end
    chk("glitch3_rises", nr[7:0], 8'd1);
    chk("glitch3_falls", nf[7:0], 8'd1);

    // Power-up reset during an active shift strobe.
    sel_i = 2'b01; id_i = 2'd3; shift_i = 1'b1; tdi_i = 1'b1; tapc_tck = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rise", {7'd0, rise_o}, 8'd1);
    chk("mid_shift", {7'd0, sh_o}, 8'd1);
    chk("mid_id", {6'd0, id_o}, 8'd3);
    pwrup_rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tapc_tck = 1'b0;
    repeat (3) @(negedge clk);
    pwrup_rst_n = 1'b1;
    nr = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nr += int'(rise_o) + int'(fall_o) + int'(f3_rise) + int'(f3_fall);
    end
    chk("rst_rel_edges", nr[7:0], 8'd0);
    chk_all_zero("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scr1_tapc_sync_mc.md
# scr1_tapc_sync_mc

Parametrised multi-channel TAP-to-core synchroniser. It runs entirely in the core `clk` domain and samples TCK and all TAP channel signals as asynchronous data. A glitch filter cleans TCK before edge detection. On each filtered TCK edge the block issues one-cycle capture/shift/TDI/update strobes and holds a level-valued channel select and ID. TDO is registered back toward the TAP. The block sits between `scr1_tapc` and the DMI/SCU channel consumers. Channel count, synchroniser depth, filter length and minimum TCK half-period are configurable. Over-speed TCK and illegal multi-channel selection set sticky error flags.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops per async input synchroniser. Legal range ≥2.
- `FILT_LEN`, default 2: consecutive equal samples needed to accept a TCK level change. Legal range 1..8.
- `MIN_HALF`, default 4: minimum legal TCK half-period in `clk` cycles. Must be ≥ `FILT_LEN`.
- `NUM_CH`, default 2: number of one-hot channel selects (bit0 SCU, bit1 DMI).
- `CH_ID_W`, default 2: channel ID width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: core clock.
- `pwrup_rst_n` in 1: async active-low reset, clears all state.
- `tapc_tck` in 1: TCK, async, sampled as data.
- `tapc_trst_n` in 1: TAP reset, async; used only after synchronisation, as a synchronous clear.
- `tapc2tapcsync_ch_sel_i` in `NUM_CH`: channel select, one-hot or zero.
- `tapc2tapcsync_ch_id_i` in `CH_ID_W`: channel ID.
- `tapc2tapcsync_ch_capture_i`, `tapc2tapcsync_ch_shift_i`, `tapc2tapcsync_ch_update_i`, `tapc2tapcsync_ch_tdi_i` in 1 each.
- `tapcsync2tapc_ch_tdo_o` out 1: registered TDO toward the TAP.
- `tapcsync2core_ch_sel_o` out `NUM_CH`: held select.
- `tapcsync2core_ch_id_o` out `CH_ID_W`: held ID.
- `tapcsync2core_ch_capture_o`, `tapcsync2core_ch_shift_o`, `tapcsync2core_ch_tdi_o` out 1 each: rise-qualified strobes.
- `tapcsync2core_ch_update_o` out 1: fall-qualified strobe.
- `core2tapcsync_ch_tdo_i` in 1: TDO from the selected channel.
- `tapcsync2core_tck_rise_o`, `tapcsync2core_tck_fall_o` out 1: one-cycle TCK edge pulses.
- `tapcsync_err_o` out 2: sticky flags. Bit0 = TCK overrun, bit1 = multi-select.

## Operation
- **Input synchronisers.** TCK, TRST_n and every TAP data input pass through `SYNC_STAGES` flops, all reset to 0. Call the synchronised values `*_s`.
- **Glitch filter.**
  - Hold a filtered level `tck_f` and a counter `fcnt`.
  - When `tck_s != tck_f`, increment `fcnt`. When `tck_s == tck_f`, clear `fcnt`.
  - When `tck_s` has differed from `tck_f` on `FILT_LEN` consecutive cycles, `tck_f` flips and `fcnt` clears.
  - With `FILT_LEN=1`, `tck_f` is `tck_s` delayed by one cycle.
- **Edge detection.**
  - A 0→1 flip of `tck_f` produces `tck_rise_o` for one cycle.
  - A 1→0 flip produces `tck_fall_o` for one cycle.
  - Both are registered.
- **Rise event.** On the same edge that asserts `tck_rise_o`:
  - `capture_o`, `shift_o` and `tdi_o` take the `*_s` values for exactly one cycle, then return to 0.
  - `ch_id_o` loads `ch_id_s` and holds it.
  - `ch_sel_o` loads `ch_sel_s` if that value is one-hot or zero. Otherwise `ch_sel_o` loads 0 and `err[1]` sets.
- **Fall event.** On the edge asserting `tck_fall_o`:
  - `update_o` takes `update_s` for one cycle.
  - `tapcsync2tapc_ch_tdo_o` loads `core2tapcsync_ch_tdo_i` and holds it until the next fall.
- **Overrun check.**
  - Counter `hcnt` clears on every `tck_f` flip, otherwise increments, saturating at `MIN_HALF`.
  - If a flip occurs while `hcnt < MIN_HALF-1`, `err[0]` sets.
  - The edge is still processed normally.
- **TAP reset.** While `trst_n_s` is 0:
  - `tck_f`, `fcnt` and `hcnt` clear (`hcnt` clears to `MIN_HALF`).
  - All strobes, sel, ID and TDO outputs clear, and `err` clears.
  - No edges are generated.
  - Release takes effect on the first cycle `trst_n_s` is 1.
- **Power-up reset.** `pwrup_rst_n` low asynchronously clears everything.
- **Width rules.**
  - `fcnt` width is clog2(`FILT_LEN`+1).
  - `hcnt` width is clog2(`MIN_HALF`+1).
  - `err` bits stay set until TAP reset or power-up reset.

## Timing
- **Reset values.** Every output is 0 after reset.
- **Latency.** A TCK transition captured into sync stage 1 at clk edge k gives:
  - `tck_s` at edge k+`SYNC_STAGES`-1,
  - `tck_f` flips at edge k+`SYNC_STAGES`+`FILT_LEN`-1,
  - edge pulse and data strobes at edge k+`SYNC_STAGES`+`FILT_LEN`.
- With defaults, latency is 4 cycles from capture to strobe.
- Strobes are high exactly 1 cycle per TCK edge and never back-to-back, given `MIN_HALF`≥2.
- Data inputs use the same `SYNC_STAGES` depth as TCK. The sampled data is therefore `FILT_LEN` cycles younger than the TCK edge; the TAP must hold data stable across that window.
- A rise and a fall can never be detected in the same cycle, because `tck_f` is a single bit.
- If TRST asserts in the same cycle as an edge pulse would be generated, TRST wins: no pulse.
- A glitch shorter than `FILT_LEN` samples produces no pulse and does not touch `hcnt`.

## Test plan
- **Clean TCK, defaults.** TCK half-period 10 clk, shift=1, tdi alternating 1,0. Required: `tck_rise_o` 4 cycles after each sampled rise; `shift_o`=1 and `tdi_o` = 1,0,… for exactly one cycle each; no errors.
- **Glitch rejection.** `FILT_LEN`=3, a 2-cycle TCK high pulse. Required: no edge pulses, `tck_f` stays 0. A 3-cycle pulse gives exactly one rise and one fall.
- **Update and TDO.** update=1 and core TDO=1 at a falling edge. Required: `update_o` one-cycle pulse with the fall, `tapcsync2tapc_ch_tdo_o`=1 held until the next fall. TDO=0 then yields 0 at the next fall.
- **Channel select.**
  - sel=2'b10, id=2'd1, then rise: `ch_sel_o`=2'b10, `ch_id_o`=1, both held.
  - sel=2'b11, then rise: `ch_sel_o`=0 and `err[1]`=1, sticky.
- **Overrun.** `MIN_HALF`=4, TCK half-period 2 clk (after filter). Required: `err[0]`=1 and edges still pulsed. Assert `tapc_trst_n`=0: `err`=0 and all outputs 0 within `SYNC_STAGES`+1 cycles.
- **Reset mid-operation.** `pwrup_rst_n` low during an active shift pulse. Required: all outputs 0 immediately. After release, no spurious edge pulse while TCK is static.
